// File: rtl/csla_pipe_if.sv
// Streaming operand/result bundle for csla_pipe: valid/ready on both sides.
interface csla_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             ovf;

  modport master (
    output in_valid, A, B, Cin, sub, out_ready,
    input  in_ready, out_valid, S, Cout, ovf
  );

  modport slave (
    input  in_valid, A, B, Cin, sub, out_ready,
    output in_ready, out_valid, S, Cout, ovf
  );
endinterface

// File: rtl/csla_pipe.sv
// Pipelined carry-select adder/subtractor: each stage resolves BLOCKS_PER_STAGE
// carry-select blocks with a registered carry chain and a global stall.
module csla_pipe #(
  parameter int WIDTH            = 16,
  parameter int BLOCK            = 4,
  parameter int BLOCKS_PER_STAGE = 1
) (
  input logic         clk,
  input logic         rst_n,
  csla_pipe_if.slave  bus
);
  localparam int NUM_BLOCKS = (BLOCK > 0) ? WIDTH / BLOCK : 1;
  localparam int STAGES     = (BLOCKS_PER_STAGE > 0) ? NUM_BLOCKS / BLOCKS_PER_STAGE : 1;
  localparam int SB         = BLOCK * BLOCKS_PER_STAGE;

  if (BLOCK < 1 || BLOCKS_PER_STAGE < 1 || (WIDTH % BLOCK) != 0 ||
      (NUM_BLOCKS % BLOCKS_PER_STAGE) != 0) begin : g_param_check
    $fatal(1, "csla_pipe: WIDTH/BLOCK/BLOCKS_PER_STAGE do not tile evenly");
  end

  // Ripple chain for one block; returns {carry_out, sum}.
  function automatic logic [BLOCK:0] add_block(input logic [BLOCK-1:0] a,
                                               input logic [BLOCK-1:0] b,
                                               input logic             cin);
    logic             c;
    logic [BLOCK-1:0] s;
    c = cin;
    s = '0;
    for (int i = 0; i < BLOCK; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return {c, s};
  endfunction

  logic w_adv;

  // One stall signal for every stage; in_ready follows out_ready combinationally.
  assign w_adv        = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int RIN = WIDTH - k * SB;

    logic [RIN-1:0]      w_a_in;
    logic [RIN-1:0]      w_b_in;
    logic                w_c_in;
    logic                w_v_in;
    logic [SB-1:0]       w_sel;
    logic                w_c_out;
    logic [(k+1)*SB-1:0] w_s_nxt;
    logic                r_v;
    logic                r_c;
    logic [(k+1)*SB-1:0] r_s;

    if (k == 0) begin : g_head
      assign w_a_in  = bus.A;
      assign w_b_in  = bus.sub ? ~bus.B : bus.B;
      assign w_c_in  = bus.Cin ^ bus.sub;
      assign w_v_in  = bus.in_valid;
      assign w_s_nxt = w_sel;
    end else begin : g_tail
      assign w_a_in  = g_stage[k-1].g_fwd.r_a;
      assign w_b_in  = g_stage[k-1].g_fwd.r_b;
      assign w_c_in  = g_stage[k-1].r_c;
      assign w_v_in  = g_stage[k-1].r_v;
      assign w_s_nxt = {w_sel, g_stage[k-1].r_s};
    end

    always_comb begin
      logic [BLOCK:0] w_r0;
      logic [BLOCK:0] w_r1;
      logic           w_c;
      // NOTE: every variable gets a value before any branch, so no latch is inferred.
      w_sel = '0;
      w_c   = w_c_in;
      for (int j = 0; j < BLOCKS_PER_STAGE; j++) begin
        w_r0 = add_block(w_a_in[j*BLOCK +: BLOCK], w_b_in[j*BLOCK +: BLOCK], 1'b0);
        w_r1 = add_block(w_a_in[j*BLOCK +: BLOCK], w_b_in[j*BLOCK +: BLOCK], 1'b1);
        w_sel[j*BLOCK +: BLOCK] = w_c ? w_r1[BLOCK-1:0] : w_r0[BLOCK-1:0];
        w_c = w_c ? w_r1[BLOCK] : w_r0[BLOCK];
      end
      w_c_out = w_c;
    end

    // NOTE: data registers are reset too, so S/Cout/ovf read 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else if (w_adv) begin
        // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
        r_v <= w_v_in;
        r_c <= w_c_out;
        r_s <= w_s_nxt;
      end
    end

    // Unresolved upper operand bits ride along with the token.
    if (RIN > SB) begin : g_fwd
      logic [RIN-SB-1:0] r_a;
      logic [RIN-SB-1:0] r_b;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_a_in[RIN-1:SB];
          r_b <= w_b_in[RIN-1:SB];
        end
      end
    end

    // Carry into the MSB is a ^ b' ^ s at that bit; overflow is it XOR Cout.
    if (k == STAGES - 1) begin : g_out
      logic r_ovf;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_adv) begin
          r_ovf <= w_a_in[SB-1] ^ w_b_in[SB-1] ^ w_sel[SB-1] ^ w_c_out;
        end
      end
    end
  end

  assign bus.out_valid = g_stage[STAGES-1].r_v;
  assign bus.S         = g_stage[STAGES-1].r_s;
  assign bus.Cout      = g_stage[STAGES-1].r_c;
  assign bus.ovf       = g_stage[STAGES-1].g_out.r_ovf;
endmodule
